// File: rtl/ysyx_22041412_memarb.sv
// ysyx_22041412_memarb
// Single-port memory arbiter/sequencer shared by instruction fetch and load/store.
// Only one transaction is in flight at a time: IDLE -> REQ -> WAIT -> RESP for
// reads, IDLE -> REQ -> RESP for writes, IDLE -> RESP for misaligned/illegal
// accesses, which never touch memory.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   if_*               fetch request/grant and one-cycle response (32-bit instruction)
//   ls_*               load/store request/grant and one-cycle completion (extended data)
//   mem_*              64-bit single memory port (valid/ready request, rvalid response)
//   busy               high whenever the sequencer is not idle
module ysyx_22041412_memarb #(
  parameter int LS_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [2:0]  ls_func3,
  output logic        ls_gnt,
  output logic        ls_done,
  output logic [63:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  localparam int SW = (LS_STREAK < 2) ? 1 : $clog2(LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(LS_STREAK);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  // Byte-enable pattern for an access of the given size code, before shifting.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      2'b11:   size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off[1:0] != 2'b00);
      2'b11:   misaligned = (off != 3'b000);
      default: misaligned = 1'b1;
    endcase
  endfunction

  // Sign/zero extension of already right-aligned load data.
  function automatic logic [63:0] load_ext(input logic [63:0] r, input logic [2:0] f3);
    case (f3)
      3'b000:  load_ext = {{56{r[7]}}, r[7:0]};
      3'b001:  load_ext = {{48{r[15]}}, r[15:0]};
      3'b010:  load_ext = {{32{r[31]}}, r[31:0]};
      3'b011:  load_ext = r;
      3'b100:  load_ext = {56'd0, r[7:0]};
      3'b101:  load_ext = {48'd0, r[15:0]};
      3'b110:  load_ext = {32'd0, r[31:0]};
      default: load_ext = 64'd0;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [SW-1:0]  streak_q, streak_d;
  logic           is_if_q, is_if_d;
  logic [2:0]     off_q, off_d;
  logic [2:0]     func3_q, func3_d;
  logic           mem_valid_q, mem_valid_d;
  logic           mem_we_q, mem_we_d;
  logic [63:0]    mem_addr_q, mem_addr_d;
  logic [63:0]    mem_wdata_q, mem_wdata_d;
  logic [7:0]     mem_wmask_q, mem_wmask_d;
  logic           if_rvalid_q, if_rvalid_d;
  logic [31:0]    if_rdata_q, if_rdata_d;
  logic           if_err_q, if_err_d;
  logic           ls_done_q, ls_done_d;
  logic [63:0]    ls_rdata_q, ls_rdata_d;
  logic           ls_err_q, ls_err_d;
  logic           busy_q, busy_d;

  logic idle_s, if_win_s, if_bad_s, ls_bad_s;

  // Arbitration: load/store wins unless fetch is alone or the streak limit is hit.
  assign idle_s   = rst && (state_q == IDLE);
  assign if_win_s = if_req && (!ls_req || (streak_q == STREAK_MAX));
  assign if_gnt   = idle_s && if_win_s;
  assign ls_gnt   = idle_s && ls_req && !if_win_s;

  // Illegal stores (unsigned size codes) and func3=111 loads are reported like misalignment.
  assign if_bad_s = (if_addr[1:0] != 2'b00);
  assign ls_bad_s = misaligned(ls_func3[1:0], ls_addr[2:0]) ||
                    (ls_we && ls_func3[2]) ||
                    (!ls_we && (ls_func3 == 3'b111));

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    is_if_d     = is_if_q;
    off_d       = off_q;
    func3_d     = func3_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    ls_done_d   = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    ls_err_d    = ls_err_q;

    // Streak only counts load/store grants that starve a waiting fetch.
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (ls_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end else begin
      streak_d = streak_q;
    end

    case (state_q)
      IDLE: begin
        if (if_gnt) begin
          is_if_d = 1'b1;
          off_d   = if_addr[2:0];
          func3_d = 3'b010;
          if (if_bad_s) begin
            state_d     = RESP;
            if_rvalid_d = 1'b1;
            if_err_d    = 1'b1;
            if_rdata_d  = 32'd0;
          end else begin
            state_d     = REQ;
            mem_valid_d = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = {if_addr[63:3], 3'b000};
            mem_wdata_d = 64'd0;
            mem_wmask_d = 8'h00;
          end
        end else if (ls_gnt) begin
          is_if_d = 1'b0;
          off_d   = ls_addr[2:0];
          func3_d = ls_func3;
          if (ls_bad_s) begin
            state_d    = RESP;
            ls_done_d  = 1'b1;
            ls_err_d   = 1'b1;
            ls_rdata_d = 64'd0;
          end else begin
            state_d     = REQ;
            mem_valid_d = 1'b1;
            mem_we_d    = ls_we;
            mem_addr_d  = {ls_addr[63:3], 3'b000};
            mem_wdata_d = ls_we ? (ls_wdata << {ls_addr[2:0], 3'b000}) : 64'd0;
            mem_wmask_d = ls_we ? (size_mask(ls_func3[1:0]) << ls_addr[2:0]) : 8'h00;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (mem_we_q) begin
            state_d    = RESP;
            ls_done_d  = 1'b1;
            ls_err_d   = 1'b0;
            ls_rdata_d = 64'd0;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = RESP;
          if (is_if_q) begin
            if_rvalid_d = 1'b1;
            if_err_d    = 1'b0;
            if_rdata_d  = off_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end else begin
            ls_done_d  = 1'b1;
            ls_err_d   = 1'b0;
            ls_rdata_d = load_ext(mem_rdata >> {off_q, 3'b000}, func3_q);
          end
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Sequencer state and all registered outputs; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      is_if_q     <= 1'b0;
      off_q       <= 3'd0;
      func3_q     <= 3'd0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      mem_wmask_q <= 8'h00;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'd0;
      if_err_q    <= 1'b0;
      ls_done_q   <= 1'b0;
      ls_rdata_q  <= 64'd0;
      ls_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      is_if_q     <= is_if_d;
      off_q       <= off_d;
      func3_q     <= func3_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      ls_done_q   <= ls_done_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_err_q    <= ls_err_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign ls_done   = ls_done_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_err    = ls_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ysyx_22041412_memarb.sv
// Directed testbench for ysyx_22041412_memarb.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. "Cycle 0" is the cycle in which the grant is observed.
module tb_ysyx_22041412_memarb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = 64'd0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [63:0] ls_addr = 64'd0;
  logic [63:0] ls_wdata = 64'd0;
  logic [2:0]  ls_func3 = 3'd0;
  logic        ls_gnt, ls_done, ls_err;
  logic [63:0] ls_rdata;
  logic        mem_valid, mem_we;
  logic        mem_ready = 1'b1;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = 64'd0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  ysyx_22041412_memarb #(.LS_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_func3(ls_func3), .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Zero-wait aligned fetch; checks grant, memory address and response timing.
  task automatic do_fetch(input string tag, input logic [63:0] addr, input logic [63:0] rd,
                          input logic [31:0] exp);
    if_req = 1'b1; if_addr = addr;
    smp(); chk({tag, "_gnt"}, 64'(if_gnt), 64'd1);
    tick(); if_req = 1'b0;
    smp(); chk({tag, "_c1_valid"}, 64'(mem_valid), 64'd1);
    chk({tag, "_c1_addr"}, mem_addr, {addr[63:3], 3'b000});
    tick(); mem_rvalid = 1'b1; mem_rdata = rd;
    smp(); chk({tag, "_c2_rvalid"}, 64'(if_rvalid), 64'd0);
    tick(); mem_rvalid = 1'b0;
    smp(); chk({tag, "_c3_rvalid"}, 64'(if_rvalid), 64'd1);
    chk({tag, "_c3_rdata"}, 64'(if_rdata), 64'(exp));
    chk({tag, "_c3_err"}, 64'(if_err), 64'd0);
    tick();
  endtask

  // Zero-wait aligned load; checks read-only memory request and extended result.
  task automatic do_load(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                         input logic [63:0] rd, input logic [63:0] exp);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = addr; ls_func3 = f3;
    smp(); chk({tag, "_gnt"}, 64'(ls_gnt), 64'd1);
    tick(); ls_req = 1'b0;
    smp(); chk({tag, "_c1_we_mask"}, {55'd0, mem_we, mem_wmask}, 64'd0);
    tick(); mem_rvalid = 1'b1; mem_rdata = rd;
    smp();
    tick(); mem_rvalid = 1'b0;
    smp(); chk({tag, "_c3_done"}, 64'(ls_done), 64'd1);
    chk({tag, "_c3_rdata"}, ls_rdata, exp);
    chk({tag, "_c3_err"}, 64'(ls_err), 64'd0);
    tick();
  endtask

  initial begin
    logic [9:0] order;
    int gcyc[10];
    int n;
    logic seen_both, seen_pulse, seen_busy;

    // Reset with both requests high: grants and outputs must be zero.
    #2 rst = 1'b0; if_req = 1'b1; ls_req = 1'b1;
    smp();
    chk("rst_grants", {62'd0, if_gnt, ls_gnt}, 64'd0);
    chk("rst_ctrl", {52'd0, mem_valid, mem_we, if_rvalid, if_err, ls_done, ls_err, busy,
                     mem_wmask[4:0]}, 64'd0);
    chk("rst_data", mem_addr | mem_wdata | ls_rdata | 64'(if_rdata), 64'd0);
    tick(); if_req = 1'b0; ls_req = 1'b0; rst = 1'b1;
    tick();

    // Fetch of upper word.
    do_fetch("fetch_hi", 64'h0000_0000_8000_0004, 64'h00000013_00100093, 32'h00000013);
    smp(); chk("fetch_after_idle", {62'd0, if_rvalid, busy}, 64'd0);
    tick();

    // Store halfword, zero wait.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_1006; ls_func3 = 3'b001; ls_wdata = 64'hABCD;
    smp(); chk("sh_gnt", 64'(ls_gnt), 64'd1);
    tick(); ls_req = 1'b0;
    smp(); chk("sh_valid_we", {62'd0, mem_valid, mem_we}, 64'd3);
    chk("sh_wmask", 64'(mem_wmask), 64'hC0);
    chk("sh_wdata", mem_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_addr", mem_addr, 64'h8000_1000);
    tick();
    smp(); chk("sh_done", {62'd0, ls_done, ls_err}, 64'd2);
    tick();

    // Store halfword with mem_ready low for three cycles.
    ls_req = 1'b1;
    smp(); chk("sh2_gnt", 64'(ls_gnt), 64'd1);
    tick(); ls_req = 1'b0; mem_ready = 1'b0;
    smp(); tick(); smp(); tick();
    smp(); chk("sh2_c3_held", {55'd0, mem_valid, mem_wmask}, {55'd1, 8'hC0});
    tick(); mem_ready = 1'b1;
    smp(); chk("sh2_c4_done", 64'(ls_done), 64'd0);
    tick();
    smp(); chk("sh2_c5_done", {62'd0, ls_done, ls_err}, 64'd2);
    tick(); ls_we = 1'b0; ls_wdata = 64'd0;

    // Byte loads: byte 3 of the word is 0x80.
    do_load("lb", 64'h8000_1003, 3'b000, 64'h11223344_80556677, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("lbu", 64'h8000_1003, 3'b100, 64'h11223344_80556677, 64'h0000_0000_0000_0080);

    // Misaligned lw: error in cycle 1, no memory access.
    ls_req = 1'b1; ls_addr = 64'h8000_1002; ls_func3 = 3'b010;
    smp(); chk("lw_mis_gnt", 64'(ls_gnt), 64'd1);
    tick(); ls_req = 1'b0;
    smp(); chk("lw_mis_c1", {61'd0, ls_done, ls_err, mem_valid}, 64'd6);
    chk("lw_mis_rdata", ls_rdata, 64'd0);
    tick();

    // Both requesters held: expect LS,LS,LS,LS,IF twice, 4 cycles apart.
    if_req = 1'b1; if_addr = 64'h8000_0000;
    ls_req = 1'b1; ls_addr = 64'h8000_1000; ls_func3 = 3'b011;
    mem_rvalid = 1'b1; mem_rdata = 64'h1;
    n = 0; order = '0; seen_both = 1'b0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      smp();
      if (if_gnt && ls_gnt) seen_both = 1'b1;
      if (if_rvalid && ls_done) seen_both = 1'b1;
      if (if_gnt || ls_gnt) begin
        order[n] = if_gnt;
        gcyc[n] = c;
        n++;
      end
      tick();
      if (n == 10) begin
        if_req = 1'b0; ls_req = 1'b0;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("arb_count", 64'(n), 64'd10);
    chk("arb_order", 64'(order), 64'h210);
    chk("arb_exclusive", 64'(seen_both), 64'd0);
    chk("arb_period", 64'(gcyc[9] - gcyc[0]), 64'd36);
    for (int c = 0; c < 20 && busy; c++) tick();
    chk("arb_drain", 64'(busy), 64'd0);
    mem_rvalid = 1'b0;
    tick();

    // Reset while in WAIT; late mem_rvalid must be ignored.
    ls_req = 1'b1; ls_addr = 64'h8000_1008; ls_func3 = 3'b011;
    smp(); chk("rw_gnt", 64'(ls_gnt), 64'd1);
    tick(); ls_req = 1'b0;
    smp(); tick();
    smp(); chk("rw_in_wait", {62'd0, busy, mem_valid}, 64'd2);
    #1 rst = 1'b0;
    #1 chk("rw_rst_ctrl", {59'd0, mem_valid, busy, ls_done, if_rvalid, ls_err}, 64'd0);
    chk("rw_rst_data", mem_addr | ls_rdata, 64'd0);
    tick(); rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    seen_pulse = 1'b0; seen_busy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      smp();
      if (ls_done || if_rvalid) seen_pulse = 1'b1;
      if (busy || mem_valid) seen_busy = 1'b1;
      tick(); mem_rvalid = 1'b0;
    end
    chk("rw_no_pulse", 64'(seen_pulse), 64'd0);
    chk("rw_idle", 64'(seen_busy), 64'd0);
    do_fetch("fetch_lo", 64'h8000_0000, 64'h00000013_00100093, 32'h00100093);

    // Misaligned fetch: error in cycle 1, no memory access.
    if_req = 1'b1; if_addr = 64'h8000_0002;
    smp(); chk("if_mis_gnt", 64'(if_gnt), 64'd1);
    tick(); if_req = 1'b0;
    smp(); chk("if_mis_c1", {61'd0, if_rvalid, if_err, mem_valid}, 64'd6);
    chk("if_mis_rdata", 64'(if_rdata), 64'd0);
    tick();
    smp(); chk("if_mis_c2_idle", {62'd0, busy, if_rvalid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
